// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and its width.
package sub_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtractor_serial_n_bit.sv
// Bit-serial N-bit unsigned subtractor (out = in_a - in_b) with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module subtractor_serial_n_bit
    import sub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N);

    state_t         state, state_nxt;
    logic [N-1:0]   a_sh, b_sh;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           accept, last;
    logic           d, br_nxt;
`ifdef SUB_OVERFLOW_EN
    logic           sa, sb;
`endif

    full_subtractor_1bit u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (br),
        .d   (d),
        .bout(br_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt == CW'(N-1)) begin
                last      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Difference bits enter the minuend register from the top as its bits leave at the bottom,
    // so after N steps a_sh holds the complete result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            out  <= '0;
            bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            sa   <= 1'b0;
            sb   <= 1'b0;
            ovf  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= in_a;
            b_sh <= in_b;
            br   <= 1'b0;
            cnt  <= '0;
`ifdef SUB_OVERFLOW_EN
            sa   <= in_a[N-1];
            sb   <= in_b[N-1];
`endif
        end else if (state == RUN) begin
            a_sh <= {d, a_sh[N-1:1]};
            b_sh <= b_sh >> 1;
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                out  <= {d, a_sh[N-1:1]};
                bout <= br_nxt;
`ifdef SUB_OVERFLOW_EN
                ovf  <= (sa != sb) && (d != sa);
`endif
            end
        end
    end
endmodule

// File: tb/tb_subtractor_serial_n_bit.sv
// Self-checking bench for subtractor_serial_n_bit (N=4): directed, random, handshake and reset cases.
module tb_subtractor_serial_n_bit;
    localparam int N = 4;

    logic         clk, rst, start;
    logic [N-1:0] in_a, in_b;
    logic         busy, done, bout;
    logic [N-1:0] out;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int nchk = 0;
    int nfail = 0;

    subtractor_serial_n_bit #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in_a (in_a),
        .in_b (in_b),
        .busy (busy),
        .done (done),
        .out  (out),
        .bout (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic on integers
    function automatic logic [N-1:0] m_diff(input int a, input int b);
        int r;
        r = (a - b + (1 << N)) % (1 << N);
        return r[N-1:0];
    endfunction

    function automatic logic m_borrow(input int a, input int b);
        return a < b;
    endfunction

    function automatic logic m_ovf(input int a, input int b);
        int sa, sb, r;
        sa = (a >= (1 << (N-1))) ? a - (1 << N) : a;
        sb = (b >= (1 << (N-1))) ? b - (1 << N) : b;
        r  = sa - sb;
        return (r > (1 << (N-1)) - 1) || (r < -(1 << (N-1)));
    endfunction

    function automatic logic get_ovf();
`ifdef SUB_OVERFLOW_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issues one operation and waits (bounded) for done; reports observations only.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] o, output logic bo, output logic ov,
                          output int edges, output int busy_cyc, output logic stable);
        logic [N-1:0] prev;
        @(negedge clk);
        prev = out;
        start = 1'b1; in_a = a; in_b = b;
        edges = 0; busy_cyc = 0; stable = 1'b1;
        @(posedge clk); edges = 1;
        @(negedge clk);
        start = 1'b0; in_a = N'($urandom); in_b = N'($urandom);
        while (!done && edges < 20) begin
            if (busy) busy_cyc++;
            if (out !== prev) stable = 1'b0;
            @(posedge clk); edges++;
            @(negedge clk);
        end
        o = out; bo = bout; ov = get_ovf();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++;
        if ({busy, done, out, bout, get_ovf()} !== '0) begin
            nfail++;
            $display("FAIL reset: busy=%b done=%b out=%b bout=%b ovf=%b, required all 0",
                     busy, done, out, bout, get_ovf());
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [N-1:0] va[3] = '{4'd3, 4'd0, 4'd15};
        logic [N-1:0] vb[3] = '{4'd1, 4'd1, 4'd15};
        logic [N-1:0] o; logic bo, ov, st; int e, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], o, bo, ov, e, bc, st);
            nchk++;
            if (o !== m_diff(va[i], vb[i]) || bo !== m_borrow(va[i], vb[i])) begin
                nfail++;
                $display("FAIL directed %0d-%0d: out=%b bout=%b, required out=%b bout=%b",
                         va[i], vb[i], o, bo, m_diff(va[i], vb[i]), m_borrow(va[i], vb[i]));
            end
            nchk++;
            if (e !== N + 1 || bc !== N) begin
                nfail++;
                $display("FAIL latency %0d-%0d: done after %0d edges, busy %0d cycles, required %0d and %0d",
                         va[i], vb[i], e, bc, N + 1, N);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, o; logic bo, ov, st; int e, bc;
        for (int i = 0; i < 24; i++) begin
            a = N'($urandom); b = N'($urandom);
            run_op(a, b, o, bo, ov, e, bc, st);
            nchk++;
            if (o !== m_diff(a, b) || bo !== m_borrow(a, b) || e !== N + 1 || !st) begin
                nfail++;
                $display("FAIL random %0d-%0d: out=%b bout=%b edges=%0d stable=%b, required out=%b bout=%b edges=%0d stable=1",
                         a, b, o, bo, e, st, m_diff(a, b), m_borrow(a, b), N + 1);
            end
`ifdef SUB_OVERFLOW_EN
            nchk++;
            if (ov !== m_ovf(a, b)) begin
                nfail++;
                $display("FAIL random ovf %0d-%0d: ovf=%b, required %b", a, b, ov, m_ovf(a, b));
            end
`endif
        end
    endtask

    task automatic test_start_during_run();
        int pulses = 0;
        logic [N-1:0] first_out = 'x;
        @(negedge clk);
        start = 1'b1; in_a = 4'd12; in_b = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; in_a = 4'd9; in_b = 4'd2;
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) first_out = out;
            end
            @(negedge clk);
        end
        nchk++;
        if (pulses !== 1 || first_out !== m_diff(12, 5)) begin
            nfail++;
            $display("FAIL start_during_run: %0d done pulses out=%b, required 1 pulse out=%b",
                     pulses, first_out, m_diff(12, 5));
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] o; logic bo, ov, st; int e, bc;
        run_op(4'd3, 4'd1, o, bo, ov, e, bc, st);
        start = 1'b1; in_a = 4'd8; in_b = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nchk++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL back_to_back restart: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        e = 1;
        while (!done && e < 20) begin
            @(negedge clk); e++;
        end
        nchk++;
        if (out !== m_diff(8, 3) || bout !== 1'b0 || e !== N + 1) begin
            nfail++;
            $display("FAIL back_to_back result: out=%b bout=%b edges=%0d, required out=%b bout=0 edges=%0d",
                     out, bout, e, m_diff(8, 3), N + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] o; logic bo, ov, st; int e, bc, pulses;
        run_op(4'd2, 4'd7, o, bo, ov, e, bc, st);
        @(negedge clk);
        start = 1'b1; in_a = 4'd10; in_b = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        nchk++;
        if ({busy, done, out, bout, get_ovf()} !== '0) begin
            nfail++;
            $display("FAIL reset_mid_run: busy=%b done=%b out=%b bout=%b, required all 0",
                     busy, done, out, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        nchk++;
        if (pulses !== 0) begin
            nfail++;
            $display("FAIL reset_mid_run aftermath: %0d cycles busy/done, required 0", pulses);
        end
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        logic [N-1:0] o; logic bo, ov, st; int e, bc;
        run_op(4'b0111, 4'b1000, o, bo, ov, e, bc, st);
        nchk++;
        if (o !== 4'b1111 || ov !== 1'b1) begin
            nfail++;
            $display("FAIL ovf_pos: out=%b ovf=%b, required out=1111 ovf=1", o, ov);
        end
        run_op(4'b0101, 4'b0011, o, bo, ov, e, bc, st);
        nchk++;
        if (o !== 4'b0010 || ov !== 1'b0) begin
            nfail++;
            $display("FAIL ovf_none: out=%b ovf=%b, required out=0010 ovf=0", o, ov);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
